// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with whole-scan debounce and game-input decode.
// Optional build macro KP_GHOST_REJECT_EN: scans with two or more pressed keys decode as no key.
module keypad_scanner #(
    parameter int SCAN_DIV       = 250,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] kp_row,
    input  logic [3:0] kp_col,
    output logic [3:0] movement,
    output logic       start,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam logic [15:0] DIV_MAX  = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_SCANS);
    localparam logic [4:0]  KEY_NONE = 5'h10;

    typedef enum logic [0:0] {ST_RELEASED = 1'b0, ST_PRESSED = 1'b1} state_t;

    state_t      r_state, w_state_n;
    logic [15:0] r_div_cnt;
    logic [1:0]  r_row_idx, w_row_next;
    logic [3:0]  r_kp_row, r_scan_key, r_movement, r_key_code;
    logic [1:0]  r_scan_cnt;
    logic [4:0]  r_cand, r_stable;
    logic [3:0]  r_agree;
    logic        r_start, r_key_valid;

    logic        w_sample, w_end_scan, w_accept;
    logic [3:0]  w_pressed, w_prev_key, w_acc_key, w_agree_n;
    logic [2:0]  w_low, w_row_cnt, w_sum;
    logic [1:0]  w_prev_cnt, w_acc_cnt;
    logic [4:0]  w_result, w_cand_n;
    logic [3:0]  w_movement_n, w_key_code_n;
    logic        w_start_n, w_key_valid_n;

    // {hit, column} of the lowest pressed column in the sampled row
    function automatic logic [2:0] lowest_col(input logic [3:0] p);
        logic [2:0] r;
        if (p[0])      r = 3'b100;
        else if (p[1]) r = 3'b101;
        else if (p[2]) r = 3'b110;
        else if (p[3]) r = 3'b111;
        else           r = 3'b000;
        return r;
    endfunction

    function automatic logic [2:0] count_keys(input logic [3:0] p);
        return 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
    endfunction

    function automatic logic [3:0] decode_move(input logic [4:0] k);
        logic [3:0] m;
        case (k)
            5'd1:    m = 4'b0001;
            5'd9:    m = 4'b0010;
            5'd4:    m = 4'b0100;
            5'd6:    m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    assign w_sample   = (r_div_cnt == DIV_MAX);
    assign w_end_scan = w_sample && (r_row_idx == 2'd3);
    assign w_row_next = r_row_idx + 2'd1;

    // Fold the current row's columns into the per-scan accumulator and form the scan result
    always_comb begin
        w_pressed = ~kp_col;
        w_low     = lowest_col(w_pressed);
        w_row_cnt = count_keys(w_pressed);
        if (r_row_idx == 2'd0) begin
            w_prev_cnt = 2'd0;
            w_prev_key = 4'd0;
        end else begin
            w_prev_cnt = r_scan_cnt;
            w_prev_key = r_scan_key;
        end
        w_sum = 3'(w_prev_cnt) + w_row_cnt;
        if (w_sum >= 3'd2) w_acc_cnt = 2'd2;
        else               w_acc_cnt = w_sum[1:0];
        if ((w_prev_cnt == 2'd0) && w_low[2]) w_acc_key = {r_row_idx, w_low[1:0]};
        else                                   w_acc_key = w_prev_key;
        if (w_acc_cnt == 2'd0)       w_result = KEY_NONE;
`ifdef KP_GHOST_REJECT_EN
        else if (w_acc_cnt >= 2'd2) w_result = KEY_NONE;
`endif
        else                         w_result = {1'b0, w_acc_key};
    end

    // Debounce candidate tracking and accept decision
    always_comb begin
        if (w_result == r_cand) begin
            w_cand_n = r_cand;
            if (r_agree >= DEB_MAX) w_agree_n = DEB_MAX;
            else                    w_agree_n = r_agree + 4'd1;
        end else begin
            w_cand_n  = w_result;
            w_agree_n = 4'd1;
        end
        w_accept = w_end_scan && (w_agree_n == DEB_MAX) && (w_cand_n != r_stable);
    end

    // Press/release FSM next state and next output values
    always_comb begin
        w_state_n     = r_state;
        w_movement_n  = r_movement;
        w_start_n     = r_start;
        w_key_code_n  = r_key_code;
        w_key_valid_n = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_accept && !w_cand_n[4]) begin
                    w_state_n     = ST_PRESSED;
                    w_key_valid_n = 1'b1;
                    w_key_code_n  = w_cand_n[3:0];
                    w_movement_n  = decode_move(w_cand_n);
                    w_start_n     = (w_cand_n == 5'd5);
                end else begin
                    w_state_n = ST_RELEASED;
                end
            end
            ST_PRESSED: begin
                if (w_accept && w_cand_n[4]) begin
                    w_state_n    = ST_RELEASED;
                    w_movement_n = 4'b0000;
                    w_start_n    = 1'b0;
                end else if (w_accept) begin
                    w_state_n     = ST_PRESSED;
                    w_key_valid_n = 1'b1;
                    w_key_code_n  = w_cand_n[3:0];
                    w_movement_n  = decode_move(w_cand_n);
                    w_start_n     = (w_cand_n == 5'd5);
                end else begin
                    w_state_n = ST_PRESSED;
                end
            end
            default: w_state_n = ST_RELEASED;
        endcase
    end

    // Row divider, row drive and per-scan accumulator registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt  <= 16'd0;
            r_row_idx  <= 2'd0;
            r_kp_row   <= 4'b1110;
            r_scan_cnt <= 2'd0;
            r_scan_key <= 4'd0;
        end else if (w_sample) begin
            r_div_cnt  <= 16'd0;
            r_row_idx  <= w_row_next;
            r_kp_row   <= ~(4'b0001 << w_row_next);
            r_scan_cnt <= w_acc_cnt;
            r_scan_key <= w_acc_key;
        end else begin
            r_div_cnt  <= r_div_cnt + 16'd1;
        end
    end

    // Debounce registers, FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cand      <= KEY_NONE;
            r_agree     <= 4'd0;
            r_stable    <= KEY_NONE;
            r_state     <= ST_RELEASED;
            r_movement  <= 4'b0000;
            r_start     <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            if (w_end_scan) begin
                r_cand  <= w_cand_n;
                r_agree <= w_agree_n;
            end else begin
                r_cand  <= r_cand;
                r_agree <= r_agree;
            end
            if (w_accept) r_stable <= w_cand_n;
            else          r_stable <= r_stable;
            r_state     <= w_state_n;
            r_movement  <= w_movement_n;
            r_start     <= w_start_n;
            r_key_code  <= w_key_code_n;
            r_key_valid <= w_key_valid_n;
        end
    end

    assign kp_row    = r_kp_row;
    assign movement  = r_movement;
    assign start     = r_start;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the LED matrix scanner. Drives a 4x4 passive keypad one row at a time, samples its columns, and debounces whole-keypad scans. It decodes the settled key into the one-hot `movement` code (UP=1, DOWN=2, LEFT=4, RIGHT=8) and the `start` level that the game core consumes. Sits between the board keypad pins and the top-level `game` inputs.

## Interface
Parameters:
- `SCAN_DIV`, 250: clk cycles each row is driven; legal range 2..65535.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a new key state; legal range 1..15.

Ports:
- `clk`, input, 1: sole clock; all logic on posedge.
- `reset`, input, 1: synchronous, active-low reset.
- `kp_row`, output, 4: row drive; active-low, exactly one bit low.
- `kp_col`, input, 4: column sense; active-low, externally pulled up.
- `movement`, output, 4: one-hot direction while a direction key is held; 0 otherwise.
- `start`, output, 1: high while the START key is held (debounced).
- `key_code`, output, 4: last accepted key, code = row*4+col.
- `key_valid`, output, 1: one-cycle pulse when a new key press is accepted.

## Operation
- `div_cnt` counts 0..SCAN_DIV-1, then wraps. `row_idx` (0..3) advances when `div_cnt`==SCAN_DIV-1.
- `kp_row` = ~(1<<row_idx), registered.
- Columns are sampled only at `div_cnt`==SCAN_DIV-1, after settling, for the row currently driven.
- Per-scan accumulator, cleared at the start of row 0:
  - `scan_key`: lowest code whose column read 0.
  - `scan_cnt`: number of pressed keys, saturating at 2.
- End of scan is the row-3 sample. The scan result is NONE if `scan_cnt`==0, else `scan_key`, subject to the ghost rule under Configuration.
- Debounce, at end of scan:
  - If the result equals `cand`, `agree` increments, saturating at DEBOUNCE_SCANS.
  - Otherwise `cand`<=result and `agree`<=1.
  - When `agree` reaches DEBOUNCE_SCANS and `cand`!=`stable`, `stable`<=`cand`.
- Debounce FSM:
  - RELEASED (stable=NONE) -> PRESSED on accepting a key.
  - PRESSED -> RELEASED on accepting NONE.
  - PRESSED -> PRESSED on accepting a different key; this also pulses `key_valid`.
- Decode of `stable`:
  - Code 1: UP. Code 9: DOWN. Code 4: LEFT. Code 6: RIGHT.
  - Code 5: START.
  - All other codes: `movement`=0 and `start`=0, but `key_code` and `key_valid` still update.
- On release, `key_code` holds the last key.

## Timing
- Reset values: `kp_row`=4'b1110, `movement`=0, `start`=0, `key_code`=0, `key_valid`=0. All counters and the accumulator are 0, `cand`=`stable`=NONE.
- Scan period is 4*SCAN_DIV cycles. The first row-0 sample occurs SCAN_DIV-1 cycles after reset deasserts.
- Outputs are registered. They change in the cycle after the end-of-scan sample that makes `agree` reach DEBOUNCE_SCANS.
- Press-to-output worst case: (DEBOUNCE_SCANS+1)*4*SCAN_DIV+1 cycles.
- A press that changes mid-scan is seen only from the rows sampled after the change. That scan therefore counts as disagreeing, and the press is accepted one scan later.
- `movement` and `start` are levels. The game samples them on its slow `fout` edge, so a level is required and a pulse is not.
- `key_valid` is exactly 1 cycle wide and is never asserted on release.
- Reset asserted mid-scan or mid-press: all state returns to reset values on the next clk. A held key must then re-debounce from zero.

## Configuration
- `KP_GHOST_REJECT_EN` defined: a scan with `scan_cnt`>=2 yields NONE, rejecting multi-key and ghosting presses.
- `KP_GHOST_REJECT_EN` undefined: such a scan yields the lowest pressed code.

## Test plan
All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=2, giving a 16-cycle scan.
- Reset: hold `reset`=0 for 3 cycles, release, `kp_col`=4'hF.
  - Required: `kp_row` sequence 1110, 1101, 1011, 0111, each held 4 cycles, repeating.
  - Required: all outputs stay 0.
- UP press: pull `kp_col[1]` low whenever `kp_row[0]`=0, held indefinitely.
  - Required: within 49 cycles, `movement`=4'b0001, `key_code`=1, and one `key_valid` pulse.
  - Required: no further `key_valid` pulses while held.
- Bounce: present key 6 for exactly 1 scan, then release.
  - Required: `movement` stays 0 and `key_valid` never pulses.
- START: hold key 5 for 5 scans, then release.
  - Required: `start`=1 and `movement`=0 during the hold.
  - Required: `start` returns to 0 two to three scans after release; `key_code` stays 5.
- Multi-key: keys 1 and 6 held together.
  - With the macro: `movement`=0 and `key_valid` never pulses.
  - Without the macro: `movement`=4'b0001 and `key_code`=1.
- Reset mid-press: key 9 accepted (`movement`=4'b0010), then `reset`=0 for 1 cycle while the key stays held.
  - Required: outputs are 0 on the next cycle and `kp_row`=1110.
  - Required: `movement`=4'b0010 again only after 2 to 3 further scans, with a new `key_valid` pulse.
